// File: rtl/burrito_segmentado_if.sv
// burrito_segmentado_if: instruction, preload and writeback signals of burrito_segmentado
interface burrito_segmentado_if #(
  parameter int ANCHO = 32,
  parameter int PROF = 32,
  parameter int OP_W = 4
);
  localparam int DIR_W = $clog2(PROF);
  logic in_valido;
  logic in_listo;
  logic [DIR_W-1:0] dir1;
  logic [DIR_W-1:0] dir2;
  logic [DIR_W-1:0] dir_es;
  logic [OP_W-1:0] selec;
  logic carga_en;
  logic [DIR_W-1:0] carga_dir;
  logic [ANCHO-1:0] carga_dato;
  logic sal_valido;
  logic [DIR_W-1:0] sal_dir;
  logic [ANCHO-1:0] sal_dato;
  logic ocupado;
  modport master (
    output in_valido, dir1, dir2, dir_es, selec, carga_en, carga_dir, carga_dato,
    input  in_listo, sal_valido, sal_dir, sal_dato, ocupado
  );
  modport slave (
    input  in_valido, dir1, dir2, dir_es, selec, carga_en, carga_dir, carga_dato,
    output in_listo, sal_valido, sal_dir, sal_dato, ocupado
  );
endinterface

// File: rtl/burrito_segmentado.sv
// burrito_segmentado: 3-stage register-file + ALU pipeline; BURRITO_FWD_EN bypasses RAW hazards instead of stalling
module burrito_segmentado #(
  parameter int ANCHO = 32,
  parameter int PROF = 32,
  parameter int OP_W = 4
) (
  input logic clk,
  input logic rst,
  burrito_segmentado_if.slave bus
);
  localparam int DIR_W = $clog2(PROF);
  logic [ANCHO-1:0] rf [PROF];
  logic e1_v, e2_v;
  logic [ANCHO-1:0] e1_a, e1_b, e2_r, alu, op_a, op_b;
  logic [OP_W-1:0] e1_op;
  logic [DIR_W-1:0] e1_d, e2_d;
  logic m1a, m1b, m2a, m2b, hazard, acc, carga;
  assign m1a = e1_v && e1_d != '0 && e1_d == bus.dir1;
  assign m1b = e1_v && e1_d != '0 && e1_d == bus.dir2;
  assign m2a = e2_v && e2_d != '0 && e2_d == bus.dir1;
  assign m2b = e2_v && e2_d != '0 && e2_d == bus.dir2;
`ifdef BURRITO_FWD_EN
  assign op_a = m1a ? alu : m2a ? e2_r : rf[bus.dir1];
  assign op_b = m1b ? alu : m2b ? e2_r : rf[bus.dir2];
  assign hazard = 1'b0;
`else
  assign op_a = rf[bus.dir1];
  assign op_b = rf[bus.dir2];
  assign hazard = m1a | m1b | m2a | m2b;
`endif
  assign bus.in_listo = !bus.carga_en && !hazard;
  assign acc = bus.in_valido && bus.in_listo;
  assign bus.ocupado = e1_v | e2_v | bus.sal_valido;
  assign carga = bus.carga_en && !bus.ocupado && !bus.in_valido;
  always_comb begin
    alu = '0;
    if (!e1_op[3])
      case (e1_op[2:0])
        3'd0: alu = e1_a + e1_b;
        3'd1: alu = e1_a - e1_b;
        3'd2: alu = e1_a & e1_b;
        3'd3: alu = e1_a | e1_b;
        3'd4: alu = e1_a ^ e1_b;
        3'd5: alu = {{(ANCHO-1){1'b0}}, $signed(e1_a) < $signed(e1_b)};
        3'd6: alu = ~(e1_a | e1_b);
        default: alu = e1_b;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      e1_v <= 1'b0;
      e2_v <= 1'b0;
      e1_a <= '0;
      e1_b <= '0;
      e1_op <= '0;
      e1_d <= '0;
      e2_r <= '0;
      e2_d <= '0;
      bus.sal_valido <= 1'b0;
      bus.sal_dir <= '0;
      bus.sal_dato <= '0;
    end else begin
      e1_v <= acc;
      if (acc) begin
        e1_a <= op_a;
        e1_b <= op_b;
        e1_op <= bus.selec;
        e1_d <= bus.dir_es;
      end
      e2_v <= e1_v;
      if (e1_v) begin
        e2_r <= alu;
        e2_d <= e1_d;
      end
      bus.sal_valido <= e2_v;
      if (e2_v) begin
        bus.sal_dir <= e2_d;
        bus.sal_dato <= e2_r;
      end
    end
  // writeback and preload never coincide: preload needs an empty pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < PROF; i++) rf[i] <= '0;
    end else if (e2_v && e2_d != '0) begin
      rf[e2_d] <= e2_r;
    end else if (carga && bus.carga_dir != '0) begin
      rf[bus.carga_dir] <= bus.carga_dato;
    end
endmodule

// File: tb/tb_burrito_segmentado.sv
// tb_burrito_segmentado: randomized and directed checks against an architectural model
module tb_burrito_segmentado;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  burrito_segmentado_if bus ();
  burrito_segmentado dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int d;
    logic [31:0] v;
    int t;
  } wb_t;
  wb_t exp_q[$], obs_q[$], hist_q[$];
  logic [31:0] m [32];
  int total = 0, bad = 0, cyc = 0, last_acc = -100;
  logic [31:0] last_v;
  int last_d;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.sal_valido === 1'b1) obs_q.push_back('{int'(bus.sal_dir), bus.sal_dato, cyc});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[3]) return 32'd0;
    case (op[2:0])
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return ~(a | b);
      default: return b;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m[i] = '0;
    hist_q.delete();
    last_acc = -100;
  endtask

  task automatic issue(input int d, input int a, input int b, input logic [3:0] op);
    int want, got, n;
    logic [31:0] res;
    @(negedge clk);
    bus.dir1 = a[4:0];
    bus.dir2 = b[4:0];
    bus.dir_es = d[4:0];
    bus.selec = op;
    bus.in_valido = 1'b1;
    #1;
    want = cyc + 1;
`ifndef BURRITO_FWD_EN
    foreach (hist_q[i])
      if (hist_q[i].d != 0 && (hist_q[i].d == a || hist_q[i].d == b) && hist_q[i].t + 3 > want) want = hist_q[i].t + 3;
`endif
    n = 0;
    while (bus.in_listo !== 1'b1 && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    got = cyc + 1;
    total++;
    if (bus.in_listo !== 1'b1 || got != want) begin
      bad++;
      $display("FAIL accept_edge d=%0d a=%0d b=%0d op=%0d got=%0d want=%0d listo=%b", d, a, b, op, got, want, bus.in_listo);
    end
    if (bus.in_listo === 1'b1) begin
      res = ref_alu(op, m[a], m[b]);
      exp_q.push_back('{d, res, got + 2});
      hist_q.push_back('{d, res, got});
      while (hist_q.size() > 2) void'(hist_q.pop_front());
      if (d != 0) m[d] = res;
      last_acc = got;
    end
    @(posedge clk);
    #1 bus.in_valido = 1'b0;
  endtask

  task automatic preload(input int d, input logic [31:0] v);
    logic busy;
    @(negedge clk);
    bus.carga_en = 1'b1;
    bus.carga_dir = d[4:0];
    bus.carga_dato = v;
    #1;
    busy = cyc <= last_acc + 2;
    total++;
    if (bus.in_listo !== 1'b0) begin
      bad++;
      $display("FAIL listo_during_carga got=%b want=0", bus.in_listo);
    end
    total++;
    if (bus.ocupado !== busy) begin
      bad++;
      $display("FAIL ocupado_at_carga got=%b want=%b", bus.ocupado, busy);
    end
    if (!busy && d != 0) m[d] = v;
    @(posedge clk);
    #1 bus.carga_en = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(negedge clk);
    #1;
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL wb_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].d != exp_q[i].d || obs_q[i].v !== exp_q[i].v || obs_q[i].t != exp_q[i].t) begin
        bad++;
        $display("FAIL wb[%0d] got dir=%0d dato=%h cyc=%0d want dir=%0d dato=%h cyc=%0d", i,
                 obs_q[i].d, obs_q[i].v, obs_q[i].t, exp_q[i].d, exp_q[i].v, exp_q[i].t);
      end
    end
    if (obs_q.size() > 0) begin
      last_v = obs_q[obs_q.size()-1].v;
      last_d = obs_q[obs_q.size()-1].d;
    end
    total++;
    if (bus.ocupado !== 1'b0) begin
      bad++;
      $display("FAIL ocupado_idle got=%b want=0", bus.ocupado);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valido = 1'b0;
    bus.dir1 = '0;
    bus.dir2 = '0;
    bus.dir_es = '0;
    bus.selec = '0;
    bus.carga_en = 1'b0;
    bus.carga_dir = '0;
    bus.carga_dato = '0;
    model_reset();
    #12;
    total++;
    if (bus.sal_valido !== 1'b0 || bus.sal_dir !== 5'd0 || bus.sal_dato !== 32'd0 || bus.ocupado !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b dir=%0d dato=%h ocup=%b want all 0", bus.sal_valido, bus.sal_dir, bus.sal_dato, bus.ocupado);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.in_listo !== 1'b1) begin
      bad++;
      $display("FAIL reset_listo got=%b want=1", bus.in_listo);
    end
  endtask

  task automatic test_basic();
    preload(1, 32'd5);
    preload(2, 32'd7);
    issue(3, 1, 2, 4'b0000);
    drain();
    total++;
    if (last_v !== 32'd12 || last_d != 3) begin
      bad++;
      $display("FAIL basic_add got dir=%0d dato=%h want dir=3 dato=c", last_d, last_v);
    end
    issue(8, 0, 3, 4'b0111);
    drain();
  endtask

  task automatic test_hazard();
    preload(4, 32'h0F);
    issue(3, 1, 2, 4'b0000);
    issue(5, 3, 4, 4'b0010);
    drain();
    total++;
    if (last_v !== 32'd12 || last_d != 5) begin
      bad++;
      $display("FAIL hazard_and got dir=%0d dato=%h want dir=5 dato=c", last_d, last_v);
    end
  endtask

  task automatic test_slt();
    issue(6, 1, 2, 4'b0101);
    drain();
    preload(1, 32'hFFFF_FFFF);
    preload(2, 32'd1);
    issue(6, 1, 2, 4'b0101);
    issue(6, 2, 1, 4'b0101);
    drain();
    total++;
    if (last_v !== 32'd0) begin
      bad++;
      $display("FAIL slt_signed got=%h want=0", last_v);
    end
  endtask

  task automatic test_r0_and_illegal();
    preload(1, 32'd5);
    preload(2, 32'd7);
    issue(0, 1, 2, 4'b0000);
    issue(7, 0, 0, 4'b0000);
    issue(11, 1, 2, 4'b1010);
    drain();
    total++;
    if (last_v !== 32'd0 || last_d != 11) begin
      bad++;
      $display("FAIL illegal_op got dir=%0d dato=%h want dir=11 dato=0", last_d, last_v);
    end
  endtask

  task automatic test_preload_busy();
    issue(12, 1, 2, 4'b0000);
    preload(9, 32'hA5);
    drain();
    issue(10, 9, 0, 4'b0000);
    drain();
    total++;
    if (last_v !== 32'd0) begin
      bad++;
      $display("FAIL preload_busy got=%h want=0", last_v);
    end
  endtask

  task automatic test_reset_mid();
    wb_t keep[$];
    issue(13, 1, 2, 4'b0000);
    issue(14, 2, 1, 4'b0001);
    issue(15, 1, 1, 4'b0100);
    @(negedge clk);
    #2 rst = 1'b1;
    foreach (exp_q[i]) if (exp_q[i].t <= cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
    model_reset();
    #1;
    total++;
    if (bus.ocupado !== 1'b0 || bus.sal_valido !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid got ocup=%b sv=%b want 0 0", bus.ocupado, bus.sal_valido);
    end
    @(negedge clk);
    rst = 1'b0;
    drain();
    for (int r = 1; r < 32; r++) issue(r, 0, r, 4'b0111);
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) preload($urandom_range(0, 7), $urandom);
      else issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 4'($urandom_range(0, 15)));
      if (k % 50 == 49) drain();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_slt();
    test_r0_and_illegal();
    test_preload_busy();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
